bin2bcd_digits: RTL and testbench

Sequential binary-to-BCD converter (iterative double-dabble) that feeds the per-digit 7-segment decoders on the DE10-Lite board.
- Accepts an unsigned binary value with a start/done handshake.
- Produces DIGITS registered BCD nibbles, one per hex7seg instance, plus a leading-zero blank mask and an overflow flag.
- Sits between the datapath that produces the value (counters, sensor readouts) and the seven-segment decode stage.

---
 rtl/bin2bcd_digits.sv | 194 +++++++++++++++++++
 tb/tb_bin2bcd_digits.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_digits.sv
// -----------------------------------------------------------------------------
// bin2bcd_digits
//
// Iterative double-dabble binary-to-BCD converter. Its outputs drive the
// per-digit hex7seg decoders on the DE10-Lite display.
//
// Handshake:
//   - A value is accepted when start=1 while ready=1.
//   - The converter spends BIN_W cycles shifting, then one cycle finishing.
//   - done pulses for one cycle when digits, blank_mask and overflow update.
//   - Results hold their previous values during a conversion, so the display
//     does not flicker.
//
// Optional feature (macro LEAD_ZERO_BLANK_EN):
//   - Defined:   blank_mask marks leading-zero digits (bit 0 is never blanked).
//   - Undefined: blank_mask is tied to zero and no mask logic is built.
//
// Parameters:
//   BIN_W  (4..32) width of the binary input
//   DIGITS (1..8)  number of BCD output digits
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   bin_in     in   unsigned value, sampled only on an accepted start
//   start      in   conversion request, honoured only when ready=1
//   ready      out  high in IDLE
//   busy       out  high while converting (inverse of ready)
//   done       out  one-cycle pulse when new results are valid
//   digits     out  BCD result, nibble k = decimal digit k (LSD at k=0)
//   blank_mask out  bit k=1 -> digit k is a leading zero
//   overflow   out  last accepted value was >= 10^DIGITS
//
// States:
//   IDLE   | waiting for start, ready=1
//   SHIFT  | one double-dabble step per cycle, BIN_W cycles
//   FINISH | register results, pulse done, return to IDLE
// -----------------------------------------------------------------------------
module bin2bcd_digits #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  start,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  overflow
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Smallest value that does not fit in DIGITS decimal digits.
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin2bcd_digits: BIN_W must be in 4..32");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bin2bcd_digits: DIGITS must be in 1..8");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   sr_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;
  logic [ACC_W-1:0]   digits_q;
  logic               done_q;
  logic               overflow_q;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift_d;
  logic               ovf_d;
  logic [ACC_W-1:0]   digits_d;

  // Add-3 correction on every nibble that would reach 10 or more after the
  // next doubling.
  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Shift the top bit of the binary register into the accumulator. The bit
  // leaving the top nibble is dropped; overflow saturation covers that case.
  assign acc_shift_d = ACC_W'({acc_adj, sr_q[BIN_W-1]});

  assign ovf_d    = (64'(bin_in) >= OVF_LIMIT);
  assign digits_d = ovf_pend_q ? {DIGITS{4'h9}} : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q       <= bin_in;
            acc_q      <= '0;
            cnt_q      <= CNT_W'(BIN_W);
            ovf_pend_q <= ovf_d;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_shift_d;
          sr_q  <= sr_q << 1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          digits_q   <= digits_d;
          overflow_q <= ovf_pend_q;
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  // Reset digits are all zero, so every digit except the LSD starts blanked.
  localparam logic [DIGITS-1:0] MASK_RST = ~(DIGITS'(1));

  logic [DIGITS-1:0] mask_d;
  logic [DIGITS-1:0] mask_q;
  logic              zero_run;

  // Walk down from the MSD; a digit is blanked while all digits from the top
  // down to it are zero. The LSD is never blanked so zero shows as "0".
  always_comb begin
    mask_d   = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run  = zero_run & (digits_d[4*k +: 4] == 4'd0);
      mask_d[k] = zero_run;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= MASK_RST;
    end else if (state_q == FINISH) begin
      mask_q <= mask_d;
    end
  end

  assign blank_mask = mask_q;
`else
  assign blank_mask = '0;
`endif

  assign ready    = (state_q == IDLE);
  assign busy     = ~ready;
  assign done     = done_q;
  assign digits   = digits_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_digits.sv
module tb_bin2bcd_digits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [19:0] bin_in;
  logic        start;
  logic        ready, busy, done, overflow;
  logic [23:0] digits;
  logic [5:0]  blank_mask;

  logic [3:0]  bin_s;
  logic        start_s;
  logic        ready_s, busy_s, done_s, ovf_s;
  logic [3:0]  digits_s;
  logic [0:0]  mask_s;

  int checks = 0;
  int errors = 0;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [5:0] M_RST = 6'b111110;
  localparam logic [5:0] M_0   = 6'b111110;
  localparam logic [5:0] M_2D  = 6'b111100;
`else
  localparam logic [5:0] M_RST = 6'b000000;
  localparam logic [5:0] M_0   = 6'b000000;
  localparam logic [5:0] M_2D  = 6'b000000;
`endif

  bin2bcd_digits #(.BIN_W(20), .DIGITS(6)) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .start(start),
    .ready(ready), .busy(busy), .done(done), .digits(digits),
    .blank_mask(blank_mask), .overflow(overflow)
  );

  bin2bcd_digits #(.BIN_W(4), .DIGITS(1)) dut_s (
    .clk(clk), .rst(rst), .bin_in(bin_s), .start(start_s),
    .ready(ready_s), .busy(busy_s), .done(done_s), .digits(digits_s),
    .blank_mask(mask_s), .overflow(ovf_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic [19:0] v);
    bin_in = v;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (done !== 1'b1 && lat < 100);
  endtask

  int lat;
  int busy_cnt, done_cnt;
  logic [23:0] cap_digits;
  logic [5:0]  cap_mask;
  logic        cap_ovf;

  initial begin
    rst = 1'b1; start = 1'b0; bin_in = '0;
    start_s = 1'b0; bin_s = '0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_digits", digits, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_mask", blank_mask, M_RST);
    step();
    rst = 1'b0;
    step();

    // zero
    start_conv(20'd0);
    chk("zero_busy", busy, 1);
    wait_done(lat);
    chk("zero_lat", lat, 21);
    chk("zero_digits", digits, 24'h000000);
    chk("zero_ovf", overflow, 0);
    chk("zero_mask", blank_mask, M_0);
    chk("zero_ready", ready, 1);
    step();
    chk("zero_done_width", done, 0);

    // 123456
    start_conv(20'd123456);
    wait_done(lat);
    chk("d123456_lat", lat, 21);
    chk("d123456_digits", digits, 24'h123456);
    chk("d123456_mask", blank_mask, 6'b000000);
    step();
    chk("d123456_done_width", done, 0);

    // 999999 then 1000000 back-to-back
    start_conv(20'd999999);
    wait_done(lat);
    chk("d999999_lat", lat, 21);
    chk("d999999_digits", digits, 24'h999999);
    chk("d999999_ovf", overflow, 0);
    bin_in = 20'd1000000;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("b2b_accept_busy", busy, 1);
    repeat (5) step();
    chk("hold_digits", digits, 24'h999999);
    chk("hold_ovf", overflow, 0);
    chk("hold_done", done, 0);
    wait_done(lat);
    chk("ovf_lat", lat, 16);
    chk("ovf_digits", digits, 24'h999999);
    chk("ovf_flag", overflow, 1);

    // 42 with start held 10 cycles and bin_in changed mid-conversion
    busy_cnt = 0; done_cnt = 0;
    cap_digits = '0; cap_mask = '0; cap_ovf = 1'b1;
    bin_in = 20'd42;
    start  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        cap_digits = digits;
        cap_mask   = blank_mask;
        cap_ovf    = overflow;
      end
      start  = (i < 10);
      bin_in = (i >= 4) ? 20'd7 : 20'd42;
    end
    chk("held_busy_cycles", busy_cnt, 21);
    chk("held_done_count", done_cnt, 1);
    chk("held_digits", cap_digits, 24'h000042);
    chk("held_mask", cap_mask, M_2D);
    chk("held_ovf", cap_ovf, 0);

    // reset during SHIFT
    start_conv(20'd500);
    repeat (7) step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_digits", digits, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_mask", blank_mask, M_RST);
    chk("mid_rst_done", done, 0);
    step();
    step();
    chk("mid_rst_no_done", done, 0);
    rst = 1'b0;
    step();
    start_conv(20'd77);
    wait_done(lat);
    chk("d77_lat", lat, 21);
    chk("d77_digits", digits, 24'h000077);
    chk("d77_mask", blank_mask, M_2D);
    step();

    // BIN_W=4, DIGITS=1 sweep
    for (int v = 0; v < 16; v++) begin
      bin_s   = 4'(v);
      start_s = 1'b1;
      step();
      start_s = 1'b0;
      lat = 0;
      do begin
        step();
        lat++;
      end while (done_s !== 1'b1 && lat < 50);
      chk("sweep_lat", lat, 5);
      chk("sweep_digit", digits_s, (v < 10) ? v : 9);
      chk("sweep_ovf", ovf_s, (v >= 10) ? 1 : 0);
      chk("sweep_mask", mask_s, 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
